// File: rtl/bpsk_pkg.sv
// rtl/bpsk_pkg.sv - shared state encoding and frame constants for the BPSK frame sequencer
package bpsk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_PREAMBLE,
    ST_SYNC,
    ST_PAYLOAD
  } state_e;

  localparam int          PREAMBLE_LEN_DEFAULT = 32;
  localparam int          SYNC_W_DEFAULT       = 16;
  localparam logic [15:0] SYNC_WORD_DEFAULT    = 16'hF628;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bpsk_frame_sequencer_if.sv
// rtl/bpsk_frame_sequencer_if.sv - byte source, datapath and status signals of the frame sequencer
interface bpsk_frame_sequencer_if;

  logic       start;
  logic [7:0] frame_len;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       sine_rdy;
  logic       data_rdy;
  logic       sine_rst;
  logic       sine_clk_en;
  logic       mod_en;
  logic       tx_bit;
  logic       busy;
  logic       done;
  logic       underrun;

  modport slave (
    input  start, frame_len, byte_data, byte_valid, sine_rdy, data_rdy,
    output byte_ready, sine_rst, sine_clk_en, mod_en, tx_bit, busy, done, underrun
  );

  modport master (
    output start, frame_len, byte_data, byte_valid, sine_rdy, data_rdy,
    input  byte_ready, sine_rst, sine_clk_en, mod_en, tx_bit, busy, done, underrun
  );

endinterface

// File: rtl/bpsk_bit_serializer.sv
// rtl/bpsk_bit_serializer.sv - payload holding register, shift register, byte handshake and counters
module bpsk_bit_serializer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       active,
  input  logic [7:0] frame_len,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       load,
  input  logic       shift,
  output logic       hold_full,
  output logic       hold_msb,
  output logic       next_bit,
  output logic       last_bit,
  output logic       last_byte
);

  logic [7:0] hold_q, hold_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] fetched_q, fetched_d;
  logic [7:0] sent_q, sent_d;
  logic [2:0] bit_q, bit_d;
  logic       hold_full_q, hold_full_d;

  assign byte_ready = active && !hold_full_q && (fetched_q < frame_len);
  assign hold_full  = hold_full_q;
  assign hold_msb   = hold_q[7];
  assign next_bit   = shift_q[6];
  assign last_bit   = (bit_q == 3'd7);
  assign last_byte  = (sent_q == frame_len);

  always_comb begin
    hold_d      = hold_q;
    shift_d     = shift_q;
    fetched_d   = fetched_q;
    sent_d      = sent_q;
    bit_d       = bit_q;
    hold_full_d = hold_full_q;
    if (clear) begin
      hold_d      = '0;
      shift_d     = '0;
      fetched_d   = '0;
      sent_d      = '0;
      bit_d       = '0;
      hold_full_d = 1'b0;
    end else begin
      if (load) begin
        shift_d     = hold_q;
        hold_full_d = 1'b0;
        bit_d       = '0;
        sent_d      = sent_q + 8'd1;
      end else if (shift) begin
        shift_d = {shift_q[6:0], 1'b0};
        bit_d   = bit_q + 3'd1;
      end
      // load needs a full holding register, so it never collides with a transfer
      if (byte_valid && byte_ready) begin
        hold_d      = byte_data;
        hold_full_d = 1'b1;
        fetched_d   = fetched_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q      <= '0;
      shift_q     <= '0;
      fetched_q   <= '0;
      sent_q      <= '0;
      bit_q       <= '0;
      hold_full_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      shift_q     <= shift_d;
      fetched_q   <= fetched_d;
      sent_q      <= sent_d;
      bit_q       <= bit_d;
      hold_full_q <= hold_full_d;
    end
  end

endmodule

// File: rtl/bpsk_frame_sequencer.sv
// rtl/bpsk_frame_sequencer.sv - frame FSM driving preamble, sync word and payload onto the BPSK datapath
module bpsk_frame_sequencer
  import bpsk_pkg::*;
#(
  parameter int                PREAMBLE_LEN = PREAMBLE_LEN_DEFAULT,
  parameter int                SYNC_W       = SYNC_W_DEFAULT,
  parameter logic [SYNC_W-1:0] SYNC_WORD    = SYNC_WORD_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  bpsk_frame_sequencer_if.slave  io
);

  localparam int CNT_W = $clog2(max_int(PREAMBLE_LEN, SYNC_W));
  localparam logic [CNT_W-1:0] LAST_PRE  = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_SYNC = CNT_W'(SYNC_W - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SYNC_W-1:0] sync_sr_q, sync_sr_d;
  logic [7:0]        frame_len_q, frame_len_d;
  logic              tx_bit_q, tx_bit_d;
  logic              done_q, done_d;
  logic              underrun_q, underrun_d;

  logic load, shift, hold_full, hold_msb, next_bit, last_bit, last_byte;
  logic idle;

  assign idle = (state_q == ST_IDLE);

  bpsk_bit_serializer u_ser (
    .clk        (clk),
    .rst        (rst),
    .clear      (idle),
    .active     (!idle),
    .frame_len  (frame_len_q),
    .byte_data  (io.byte_data),
    .byte_valid (io.byte_valid),
    .byte_ready (io.byte_ready),
    .load       (load),
    .shift      (shift),
    .hold_full  (hold_full),
    .hold_msb   (hold_msb),
    .next_bit   (next_bit),
    .last_bit   (last_bit),
    .last_byte  (last_byte)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sync_sr_d   = sync_sr_q;
    frame_len_d = frame_len_q;
    tx_bit_d    = tx_bit_q;
    done_d      = 1'b0;
    underrun_d  = 1'b0;
    load        = 1'b0;
    shift       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_bit_d = 1'b0;
        if (io.start) begin
          frame_len_d = io.frame_len;
          state_d     = ST_WARMUP;
        end
      end
      ST_WARMUP: begin
        if (io.sine_rdy) begin
          state_d  = ST_PREAMBLE;
          cnt_d    = '0;
          tx_bit_d = 1'b1;
        end
      end
      ST_PREAMBLE: begin
        if (io.data_rdy) begin
          if (cnt_q == LAST_PRE) begin
            state_d   = ST_SYNC;
            cnt_d     = '0;
            tx_bit_d  = SYNC_WORD[SYNC_W-1];
            sync_sr_d = SYNC_WORD << 1;
          end else begin
            cnt_d    = cnt_q + 1'b1;
            tx_bit_d = ~tx_bit_q;
          end
        end
      end
      ST_SYNC: begin
        if (io.data_rdy) begin
          if (cnt_q != LAST_SYNC) begin
            cnt_d     = cnt_q + 1'b1;
            tx_bit_d  = sync_sr_q[SYNC_W-1];
            sync_sr_d = {sync_sr_q[SYNC_W-2:0], 1'b0};
          end else if (frame_len_q == 8'd0) begin
            done_d   = 1'b1;
            state_d  = ST_IDLE;
            tx_bit_d = 1'b0;
          end else if (hold_full) begin
            load     = 1'b1;
            tx_bit_d = hold_msb;
            state_d  = ST_PAYLOAD;
          end else begin
            underrun_d = 1'b1;
            state_d    = ST_IDLE;
            tx_bit_d   = 1'b0;
          end
        end
      end
      ST_PAYLOAD: begin
        // the holding register is judged on its registered state, so a same-cycle byte is too late
        if (io.data_rdy) begin
          if (!last_bit) begin
            shift    = 1'b1;
            tx_bit_d = next_bit;
          end else if (last_byte) begin
            done_d   = 1'b1;
            state_d  = ST_IDLE;
            tx_bit_d = 1'b0;
          end else if (hold_full) begin
            load     = 1'b1;
            tx_bit_d = hold_msb;
          end else begin
            underrun_d = 1'b1;
            state_d    = ST_IDLE;
            tx_bit_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        tx_bit_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sync_sr_q   <= '0;
      frame_len_q <= '0;
      tx_bit_q    <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_sr_q   <= sync_sr_d;
      frame_len_q <= frame_len_d;
      tx_bit_q    <= tx_bit_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
    end
  end

  assign io.sine_rst    = idle;
  assign io.sine_clk_en = !idle;
  assign io.mod_en      = (state_q == ST_PREAMBLE) || (state_q == ST_SYNC) || (state_q == ST_PAYLOAD);
  assign io.busy        = !idle;
  assign io.tx_bit      = tx_bit_q;
  assign io.done        = done_q;
  assign io.underrun    = underrun_q;

endmodule

// File: tb/tb_bpsk_frame_sequencer.sv
// tb/tb_bpsk_frame_sequencer.sv - directed self-checking bench for bpsk_frame_sequencer
module tb_bpsk_frame_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bpsk_frame_sequencer_if bus ();

  bpsk_frame_sequencer dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] SYNC_REF = 16'hF628;

  int n_checks = 0;
  int n_err    = 0;
  int done_cnt, underrun_cnt, xfer_cnt, ready_cnt;
  logic [7:0] feed_bytes [0:7];
  int feed_n, feed_idx;

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input int k);
    logic [7:0] b;
    if (k < 32) return (k % 2) == 0;
    if (k < 48) return SYNC_REF[15 - (k - 32)];
    b = feed_bytes[(k - 48) / 8];
    return b[7 - ((k - 48) % 8)];
  endfunction

  task automatic update_feed();
    if (feed_idx < feed_n) begin
      bus.byte_valid = 1'b1;
      bus.byte_data  = feed_bytes[feed_idx];
    end else begin
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;
    end
  endtask

  task automatic cycle();
    logic xfer;
    @(negedge clk);
    xfer = bus.byte_valid && bus.byte_ready;
    if (xfer) xfer_cnt++;
    if (bus.byte_ready) ready_cnt++;
    if (bus.done) done_cnt++;
    if (bus.underrun) underrun_cnt++;
    @(posedge clk);
    #1;
    if (xfer) begin
      feed_idx++;
      update_feed();
    end
  endtask

  task automatic new_frame(input int n);
    done_cnt = 0; underrun_cnt = 0; xfer_cnt = 0; ready_cnt = 0;
    feed_idx = 0; feed_n = n;
    update_feed();
  endtask

  task automatic start_frame(input logic [7:0] flen);
    bus.frame_len = flen;
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
  endtask

  task automatic send_bits(input int first, input int n);
    for (int k = first; k < first + n; k++) begin
      chk_b($sformatf("tx_bit[%0d]", k), bus.tx_bit, exp_bit(k));
      bus.data_rdy = 1'b1;
      cycle();
      bus.data_rdy = 1'b0;
      if (k != first + n - 1) repeat (7) cycle();
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.frame_len = 8'd0; bus.byte_data = 8'd0; bus.byte_valid = 1'b0;
    bus.sine_rdy = 1'b1; bus.data_rdy = 1'b0;
    feed_n = 0; feed_idx = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_b("rst_sine_rst", bus.sine_rst, 1'b1);
    chk_b("rst_clk_en", bus.sine_clk_en, 1'b0);
    chk_b("rst_mod_en", bus.mod_en, 1'b0);
    chk_b("rst_busy", bus.busy, 1'b0);
    chk_b("rst_tx_bit", bus.tx_bit, 1'b0);
    chk_b("rst_done", bus.done, 1'b0);
    rst = 1'b0;
    cycle();

    // 1: two-byte frame, bytes available early
    feed_bytes[0] = 8'hA5; feed_bytes[1] = 8'h3C;
    new_frame(2);
    start_frame(8'd2);
    chk_b("s1_warm_busy", bus.busy, 1'b1);
    chk_b("s1_warm_sine_rst", bus.sine_rst, 1'b0);
    chk_b("s1_warm_clk_en", bus.sine_clk_en, 1'b1);
    chk_b("s1_warm_mod_en", bus.mod_en, 1'b0);
    cycle();
    chk_b("s1_pre_mod_en", bus.mod_en, 1'b1);
    send_bits(0, 63);
    repeat (7) cycle();
    chk_i("s1_no_early_done", done_cnt, 0);
    send_bits(63, 1);
    chk_b("s1_done_pulse", bus.done, 1'b1);
    chk_b("s1_end_mod_en", bus.mod_en, 1'b0);
    chk_b("s1_end_sine_rst", bus.sine_rst, 1'b1);
    repeat (4) cycle();
    chk_i("s1_done_count", done_cnt, 1);
    chk_i("s1_xfers", xfer_cnt, 2);
    chk_b("s1_idle", bus.busy, 1'b0);

    // 2: empty payload
    feed_bytes[0] = 8'hFF;
    new_frame(1);
    start_frame(8'd0);
    cycle();
    send_bits(0, 48);
    chk_b("s2_done_pulse", bus.done, 1'b1);
    repeat (4) cycle();
    chk_i("s2_done_count", done_cnt, 1);
    chk_i("s2_ready_never", ready_cnt, 0);
    chk_b("s2_idle", bus.busy, 1'b0);

    // 3: third byte withheld
    feed_bytes[0] = 8'h11; feed_bytes[1] = 8'h22;
    new_frame(2);
    start_frame(8'd3);
    cycle();
    send_bits(0, 64);
    chk_b("s3_underrun_pulse", bus.underrun, 1'b1);
    chk_b("s3_mod_en", bus.mod_en, 1'b0);
    chk_b("s3_sine_rst", bus.sine_rst, 1'b1);
    repeat (4) cycle();
    chk_i("s3_underrun_count", underrun_cnt, 1);
    chk_i("s3_no_done", done_cnt, 0);

    // 4: sine generator slow to prime
    bus.sine_rdy = 1'b0;
    feed_bytes[0] = 8'h5A;
    new_frame(1);
    start_frame(8'd1);
    for (int i = 0; i < 100; i++) begin
      bus.data_rdy = (i % 8) == 3;
      cycle();
    end
    bus.data_rdy = 1'b0;
    chk_b("s4_wait_busy", bus.busy, 1'b1);
    chk_b("s4_wait_mod_en", bus.mod_en, 1'b0);
    chk_b("s4_wait_clk_en", bus.sine_clk_en, 1'b1);
    bus.sine_rdy = 1'b1;
    cycle();
    chk_b("s4_pre_mod_en", bus.mod_en, 1'b1);
    send_bits(0, 56);
    chk_b("s4_done_pulse", bus.done, 1'b1);
    repeat (4) cycle();
    chk_i("s4_done_count", done_cnt, 1);

    // 5: reset in the middle of the payload
    feed_bytes[0] = 8'h81; feed_bytes[1] = 8'h7E;
    new_frame(2);
    start_frame(8'd2);
    cycle();
    send_bits(0, 52);
    chk_b("s5_mid_mod_en", bus.mod_en, 1'b1);
    rst = 1'b1;
    #1;
    chk_b("s5_rst_sine_rst", bus.sine_rst, 1'b1);
    chk_b("s5_rst_mod_en", bus.mod_en, 1'b0);
    chk_b("s5_rst_busy", bus.busy, 1'b0);
    chk_b("s5_rst_byte_ready", bus.byte_ready, 1'b0);
    chk_b("s5_rst_done", bus.done, 1'b0);
    chk_b("s5_rst_underrun", bus.underrun, 1'b0);
    cycle();
    rst = 1'b0;
    feed_bytes[0] = 8'hC3;
    new_frame(1);
    start_frame(8'd1);
    cycle();
    send_bits(0, 56);
    chk_b("s5_clean_done", bus.done, 1'b1);
    repeat (4) cycle();
    chk_i("s5_done_count", done_cnt, 1);
    chk_i("s5_underrun_count", underrun_cnt, 0);

    // 6: start while busy ignored; byte arriving with the deciding data_rdy is too late
    feed_bytes[0] = 8'h96;
    new_frame(0);
    start_frame(8'd1);
    bus.frame_len = 8'd0;
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    send_bits(0, 47);
    repeat (7) cycle();
    feed_n = 1;
    update_feed();
    chk_b("tx_bit[47]", bus.tx_bit, exp_bit(47));
    bus.data_rdy = 1'b1;
    cycle();
    bus.data_rdy = 1'b0;
    chk_b("s6_underrun_pulse", bus.underrun, 1'b1);
    chk_b("s6_no_done_pulse", bus.done, 1'b0);
    chk_b("s6_mod_en", bus.mod_en, 1'b0);
    repeat (10) cycle();
    chk_i("s6_underrun_count", underrun_cnt, 1);
    chk_i("s6_done_count", done_cnt, 0);
    chk_i("s6_late_xfer", xfer_cnt, 1);
    chk_b("s6_idle", bus.busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
